// File: rtl/evm_div_pkg.sv
// +--------------------------------------------------------------------+
// | evm_div_pkg                                                        |
// | Shared constants and scheduler state encoding for vote_share_*.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package evm_div_pkg;

    localparam int PCT_SCALE      = 100;
    localparam int PCT_MAX        = 100;
    localparam int NUM_EXTRA_BITS = 7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV  = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// +--------------------------------------------------------------------+
// | seq_divider                                                        |
// | Restoring divider, one quotient bit per clock; load does bit one.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_divider #(
    parameter int NW    = 14,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [NW-1:0]    dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             q_valid,
    output logic [NW-1:0]    quotient
);

    localparam int CW = $clog2(NW + 1);

    logic [WIDTH-1:0] r_rem;
    logic [NW-1:0]    r_quot;
    logic [WIDTH-1:0] r_dsr;
    logic [CW-1:0]    r_cnt;
    logic             r_q_valid;

    logic [WIDTH-1:0] w_rem_in;
    logic [NW-1:0]    w_q_in;
    logic [WIDTH-1:0] w_dsr;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_rem_nxt;
    logic [NW-1:0]    w_q_nxt;

    // The first iteration runs on the load edge so the result lands NW edges later.
    always_comb begin
        w_rem_in = load ? '0 : r_rem;
        w_q_in   = load ? dividend : r_quot;
        w_dsr    = load ? divisor : r_dsr;
        w_shift  = {w_rem_in, w_q_in[NW-1]};
        if (w_shift >= {1'b0, w_dsr}) begin
            w_rem_nxt = w_shift - {1'b0, w_dsr};
            w_q_nxt   = {w_q_in[NW-2:0], 1'b1};
        end else begin
            w_rem_nxt = w_shift;
            w_q_nxt   = {w_q_in[NW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_dsr     <= '0;
            r_cnt     <= '0;
            r_q_valid <= 1'b0;
        end else if (load) begin
            r_rem     <= WIDTH'(w_rem_nxt);
            r_quot    <= w_q_nxt;
            r_dsr     <= divisor;
            r_cnt     <= CW'(NW - 1);
            r_q_valid <= 1'b0;
        end else if (r_cnt != '0) begin
            r_rem     <= WIDTH'(w_rem_nxt);
            r_quot    <= w_q_nxt;
            r_cnt     <= r_cnt - 1'b1;
            r_q_valid <= (r_cnt == CW'(1));
        end else begin
            r_q_valid <= 1'b0;
        end
    end

    assign busy     = (r_cnt != '0);
    assign q_valid  = r_q_valid;
    assign quotient = r_quot;

endmodule

`default_nettype wire

// File: rtl/vote_share_scheduler.sv
// +--------------------------------------------------------------------+
// | vote_share_scheduler                                               |
// | Sweeps one shared divider over all tallies; VOTE_ROUND_EN rounds.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module vote_share_scheduler
    import evm_div_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int WIDTH    = 7,
    parameter int IDXW     = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NUM_CAND*WIDTH-1:0] tally_flat,
    input  logic [WIDTH-1:0]          total,
    input  logic                      pct_ready,
    output logic                      busy,
    output logic                      pct_valid,
    output logic [IDXW-1:0]           pct_idx,
    output logic [WIDTH-1:0]          pct_out,
    output logic                      done,
    output logic                      div_by_zero
);

    localparam int              NW       = WIDTH + NUM_EXTRA_BITS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CAND - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_tally [NUM_CAND];
    logic [WIDTH-1:0] r_total;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_pct;
    logic             r_dbz;

    logic             w_zero_total;
    logic             w_load;
    logic             w_div_busy;
    logic             w_div_qv;
    logic [NW-1:0]    w_num;
    logic [NW-1:0]    w_quot;
    logic [WIDTH-1:0] w_pct_sat;

    assign w_zero_total = (r_total == '0);

`ifdef VOTE_ROUND_EN
    assign w_num = NW'(r_tally[r_idx]) * NW'(PCT_SCALE) + NW'(r_total >> 1);
`else
    assign w_num = NW'(r_tally[r_idx]) * NW'(PCT_SCALE);
`endif

    // Quotient exceeds 100 only when a tally is larger than the total.
    assign w_pct_sat = (w_quot > NW'(PCT_MAX)) ? WIDTH'(PCT_MAX) : WIDTH'(w_quot);

    seq_divider #(
        .NW    (NW),
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .dividend (w_num),
        .divisor  (r_total),
        .busy     (w_div_busy),
        .q_valid  (w_div_qv),
        .quotient (w_quot)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_zero_total) begin
                    w_state_nxt = S_EMIT;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = S_DIV;
                end
            end
            S_DIV:  if (w_div_qv && !w_div_busy) w_state_nxt = S_EMIT;
            S_EMIT: if (pct_ready) w_state_nxt = (r_idx == LAST_IDX) ? S_DONE : S_LOAD;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
            r_total <= '0;
            r_idx   <= '0;
            r_pct   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= tally_flat[i*WIDTH +: WIDTH];
                        r_total <= total;
                        r_idx   <= '0;
                        r_dbz   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_zero_total) begin
                        r_dbz <= 1'b1;
                        r_pct <= '0;
                    end
                end
                S_DIV:  if (w_div_qv) r_pct <= w_pct_sat;
                S_EMIT: if (pct_ready && r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign pct_valid   = (r_state == S_EMIT);
    assign done        = (r_state == S_DONE);
    assign pct_idx     = r_idx;
    assign pct_out     = r_pct;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_vote_share_scheduler.sv
// +--------------------------------------------------------------------+
// | tb_vote_share_scheduler                                            |
// | Scoreboard bench: expected percentages queued at start, popped.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_vote_share_scheduler;

    localparam int NUM_CAND = 4;
    localparam int WIDTH    = 7;

    logic                      clk        = 1'b0;
    logic                      rst_n      = 1'b0;
    logic                      start      = 1'b0;
    logic                      pct_ready  = 1'b1;
    logic [NUM_CAND*WIDTH-1:0] tally_flat = '0;
    logic [WIDTH-1:0]          total      = '0;
    logic                      busy;
    logic                      pct_valid;
    logic [1:0]                pct_idx;
    logic [WIDTH-1:0]          pct_out;
    logic                      done;
    logic                      div_by_zero;

    typedef struct {
        int idx;
        int pct;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   e0        = 0;
    int   first_cyc = -1;
    logic hold_v    = 1'b0;
    int   hold_idx  = 0;
    int   hold_pct  = 0;

    vote_share_scheduler #(
        .NUM_CAND (NUM_CAND),
        .WIDTH    (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .tally_flat  (tally_flat),
        .total       (total),
        .pct_ready   (pct_ready),
        .busy        (busy),
        .pct_valid   (pct_valid),
        .pct_idx     (pct_idx),
        .pct_out     (pct_out),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_pct(input int t, input int tot);
        int n;
        int q;
        if (tot == 0) return 0;
        n = t * 100;
`ifdef VOTE_ROUND_EN
        n = n + tot / 2;
`endif
        q = n / tot;
        return (q > 100) ? 100 : q;
    endfunction

    // Output monitor: hold stability under backpressure, scoreboard pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pct_valid && hold_v) begin
                check("hold_idx", int'(pct_idx), hold_idx);
                check("hold_pct", int'(pct_out), hold_pct);
            end
            if (pct_valid && first_cyc < 0) first_cyc = cyc - e0;
            if (pct_valid && pct_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", sb_q.size(), 1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("pct_idx", int'(pct_idx), e.idx);
                    check("pct_out", int'(pct_out), e.pct);
                end
            end
            hold_v   = pct_valid && !pct_ready;
            hold_idx = int'(pct_idx);
            hold_pct = int'(pct_out);
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic start_sweep(input int t0, input int t1, input int t2, input int t3, input int tot);
        int t[4];
        t = '{t0, t1, t2, t3};
        @(posedge clk); #1;
        for (int i = 0; i < NUM_CAND; i++) begin
            tally_flat[i*WIDTH +: WIDTH] = WIDTH'(t[i]);
            sb_q.push_back('{idx: i, pct: exp_pct(t[i], tot)});
        end
        total     = WIDTH'(tot);
        first_cyc = -1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e0    = cyc - 1;
    endtask

    task automatic wait_done(output int dc);
        int seen;
        seen = 0;
        dc   = -1;
        for (int i = 0; i < 300 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                dc   = cyc - e0;
            end
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        int dc;
        int seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(pct_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        check("rst_idx", int'(pct_idx), 0);
        check("rst_pct", int'(pct_out), 0);
        rst_n = 1'b1;

        // Nominal sweep with latency checks.
        start_sweep(10, 20, 30, 40, 100);
        check("busy_after_start", int'(busy), 1);
        wait_done(dc);
        check("t1_first_valid", first_cyc, 16);
        check("t1_done_cyc", dc, 65);
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);
        check("busy_idle", int'(busy), 0);
        check("t1_sb_empty", sb_q.size(), 0);

        // Rounding-sensitive ratio.
        start_sweep(2, 1, 0, 0, 3);
        wait_done(dc);
        check("t2_done_cyc", dc, 65);
        check("t2_sb_empty", sb_q.size(), 0);

        // Zero total: two cycles per candidate, flag held.
        start_sweep(5, 9, 100, 127, 0);
        wait_done(dc);
        check("t3_first_valid", first_cyc, 2);
        check("t3_done_cyc", dc, 9);
        check("t3_dbz", int'(div_by_zero), 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_done_ignored", int'(busy), 0);
        check("t3_dbz_held", int'(div_by_zero), 1);
        check("t3_sb_empty", sb_q.size(), 0);

        // Saturation, post-latch input changes and stray start pulses.
        start_sweep(50, 20, 0, 7, 20);
        check("dbz_cleared", int'(div_by_zero), 0);
        tally_flat = '1;
        total      = 7'd1;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(dc);
        check("t4_done_cyc", dc, 65);
        check("t4_sb_empty", sb_q.size(), 0);

        // Backpressure on idx 1 for five cycles.
        start_sweep(3, 60, 25, 12, 100);
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (pct_valid && pct_idx == 2'd1) seen = 1;
        end
        check("t5_idx1_seen", seen, 1);
        pct_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pct_ready = 1'b1;
        wait_done(dc);
        check("t5_done_cyc", dc, 70);
        check("t5_sb_empty", sb_q.size(), 0);

        // Asynchronous reset in the middle of idx 2's division.
        start_sweep(10, 20, 30, 40, 100);
        repeat (39) @(posedge clk);
        #1;
        check("t6_pre_idx", int'(pct_idx), 2);
        check("t6_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", int'(busy), 0);
        check("t6_valid", int'(pct_valid), 0);
        check("t6_done", int'(done), 0);
        check("t6_dbz", int'(div_by_zero), 0);
        check("t6_idx", int'(pct_idx), 0);
        check("t6_pct", int'(pct_out), 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_sweep(40, 30, 20, 10, 100);
        wait_done(dc);
        check("t6_done_cyc", dc, 65);
        check("t6_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
